reg_rename_file: RTL and testbench

- Architectural register file with per-register rename tags for the Tomasulo out-of-order core.
- Sits on the far side of the reorder buffer's register interfaces:
  - Accepts rename requests at issue (rd → RoB tag).
  - Accepts in-order commit writes from the RoB head.
  - Serves two combinational operand lookups to the issue stage.
- Each operand lookup returns either a ready value or the RoB tag the operand waits on.

---
 rtl/reg_rename_file.sv | 131 +++++++++++++
 tb/tb_reg_rename_file.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file with per-register rename tags
// for the Tomasulo out-of-order core.
//
// The issue stage renames a destination register to a RoB tag. The RoB head
// writes committed values back in order. Two combinational read ports return
// either a ready value or the tag the operand is waiting on.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global hold when low)
//   issue_rdy / issue_rd / issue_rob_id         - rename request
//   commit_rdy / commit_rd / commit_value /
//   commit_rob_id                               - in-order commit write
//   flush_in                                    - drop all outstanding renames
//   rs1/rs2 -> rsX_busy / rsX_value / rsX_tag   - operand lookups
//
// Optional feature, enabled by defining REGFILE_COMMIT_BYPASS_EN: a commit
// that retires the pending producer of a read operand is forwarded to that
// read port in the same cycle. Without it, reads see registered state only.

// One architectural register: value, busy flag and producing RoB tag.
module reg_rename_entry #(
    parameter int ROB_BITS = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                commit_en,
    input  logic [31:0]         commit_value,
    input  logic [ROB_BITS-1:0] commit_rob_id,
    input  logic                issue_en,
    input  logic [ROB_BITS-1:0] issue_rob_id,
    input  logic                flush_in,
    output logic [31:0]         value,
    output logic                busy,
    output logic [ROB_BITS-1:0] tag
);
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            value <= '0;
            busy  <= 1'b0;
            tag   <= '0;
        end else if (rdy_in) begin
            // The value is always written; only the busy/tag state is
            // subject to the flush > issue > commit priority.
            if (commit_en) value <= commit_value;
            if (flush_in) begin
                busy <= 1'b0;
            end else if (issue_en) begin
                busy <= 1'b1;
                tag  <= issue_rob_id;
            end else if (commit_en && tag == commit_rob_id) begin
                // A mismatched tag means a younger rename still owns the register.
                busy <= 1'b0;
            end
        end
    end
endmodule

module reg_rename_file #(
    parameter int ROB_BITS = 4,
    parameter int NREG     = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                issue_rdy,
    input  logic [4:0]          issue_rd,
    input  logic [ROB_BITS-1:0] issue_rob_id,
    input  logic                commit_rdy,
    input  logic [4:0]          commit_rd,
    input  logic [31:0]         commit_value,
    input  logic [ROB_BITS-1:0] commit_rob_id,
    input  logic                flush_in,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    output logic                rs1_busy,
    output logic [31:0]         rs1_value,
    output logic [ROB_BITS-1:0] rs1_tag,
    output logic                rs2_busy,
    output logic [31:0]         rs2_value,
    output logic [ROB_BITS-1:0] rs2_tag
);
    logic [NREG-1:0][31:0]         value_q;
    logic [NREG-1:0]               busy_q;
    logic [NREG-1:0][ROB_BITS-1:0] tag_q;

    // x0 has no storage: it always reads as a ready zero.
    assign value_q[0] = '0;
    assign busy_q[0]  = 1'b0;
    assign tag_q[0]   = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        reg_rename_entry #(.ROB_BITS(ROB_BITS)) u_entry (
            .clk_in        (clk_in),
            .rst_in        (rst_in),
            .rdy_in        (rdy_in),
            .commit_en     (commit_rdy && commit_rd == 5'(i)),
            .commit_value  (commit_value),
            .commit_rob_id (commit_rob_id),
            .issue_en      (issue_rdy && issue_rd == 5'(i)),
            .issue_rob_id  (issue_rob_id),
            .flush_in      (flush_in),
            .value         (value_q[i]),
            .busy          (busy_q[i]),
            .tag           (tag_q[i])
        );
    end

    // Reads see registered state only, so a same-cycle rename of a source
    // is not visible to the instruction that is reading it.
    always_comb begin
        rs1_busy  = busy_q[rs1];
        rs1_value = value_q[rs1];
        rs1_tag   = tag_q[rs1];
        rs2_busy  = busy_q[rs2];
        rs2_value = value_q[rs2];
        rs2_tag   = tag_q[rs2];
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (commit_rdy && rs1 != 5'd0 && commit_rd == rs1 &&
            busy_q[rs1] && tag_q[rs1] == commit_rob_id) begin
            rs1_busy  = 1'b0;
            rs1_value = commit_value;
        end
        if (commit_rdy && rs2 != 5'd0 && commit_rd == rs2 &&
            busy_q[rs2] && tag_q[rs2] == commit_rob_id) begin
            rs2_busy  = 1'b0;
            rs2_value = commit_value;
        end
`endif
    end
endmodule

// File: tb/tb_reg_rename_file.sv
// Scoreboard bench for reg_rename_file: the stimulus process pushes the
// expected read-port response for each cycle, and a monitor pops and
// compares it at the falling edge.
module tb_reg_rename_file;
    localparam int RB = 4;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in = 1'b1;
    logic          issue_rdy = 1'b0;
    logic [4:0]    issue_rd = '0;
    logic [RB-1:0] issue_rob_id = '0;
    logic          commit_rdy = 1'b0;
    logic [4:0]    commit_rd = '0;
    logic [31:0]   commit_value = '0;
    logic [RB-1:0] commit_rob_id = '0;
    logic          flush_in = 1'b0;
    logic [4:0]    rs1 = '0;
    logic [4:0]    rs2 = '0;
    logic          rs1_busy, rs2_busy;
    logic [31:0]   rs1_value, rs2_value;
    logic [RB-1:0] rs1_tag, rs2_tag;

    reg_rename_file #(.ROB_BITS(RB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_rdy(issue_rdy), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
        .commit_rdy(commit_rdy), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_rob_id(commit_rob_id), .flush_in(flush_in),
        .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs1_value(rs1_value), .rs1_tag(rs1_tag),
        .rs2_busy(rs2_busy), .rs2_value(rs2_value), .rs2_tag(rs2_tag)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string         name;
        logic          b1;
        logic [31:0]   v1;
        logic [RB-1:0] t1;
        logic          b2;
        logic [31:0]   v2;
        logic [RB-1:0] t2;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: one entry per architectural register.
    logic [31:0]   m_val [32];
    logic          m_busy[32];
    logic [RB-1:0] m_tag [32];

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
    endfunction

    // What an operand lookup should return given the current state and the
    // commit currently being presented.
    function automatic void model_read(input logic [4:0] rs, input logic com,
                                       input logic [4:0] crd, input logic [31:0] cval,
                                       input logic [RB-1:0] cid, output logic b,
                                       output logic [31:0] v, output logic [RB-1:0] t);
        b = 1'b0; v = '0; t = '0;
        if (rs != 0) begin
            b = m_busy[rs]; v = m_val[rs]; t = m_tag[rs];
`ifdef REGFILE_COMMIT_BYPASS_EN
            if (com && crd == rs && m_busy[rs] && m_tag[rs] == cid) begin
                b = 1'b0; v = cval;
            end
`endif
        end
    endfunction

    // One clock of stimulus: drive, predict the reads, then advance the model.
    task automatic cyc(input string name, input logic rst, input logic rdy,
                       input logic iss, input logic [4:0] ird, input logic [RB-1:0] iid,
                       input logic com, input logic [4:0] crd, input logic [31:0] cval,
                       input logic [RB-1:0] cid, input logic fl,
                       input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        rst_in = rst; rdy_in = rdy;
        issue_rdy = iss; issue_rd = ird; issue_rob_id = iid;
        commit_rdy = com; commit_rd = crd; commit_value = cval; commit_rob_id = cid;
        flush_in = fl; rs1 = r1; rs2 = r2;
        if (!rst) model_clear();
        e.name = name;
        model_read(r1, com, crd, cval, cid, e.b1, e.v1, e.t1);
        model_read(r2, com, crd, cval, cid, e.b2, e.v2, e.t2);
        exp_q.push_back(e);
        if (rst && rdy) begin
            if (com && crd != 0) begin
                m_val[crd] = cval;
                if (m_tag[crd] == cid) m_busy[crd] = 1'b0;
            end
            if (iss && ird != 0 && !fl) begin
                m_busy[ird] = 1'b1; m_tag[ird] = iid;
            end
            if (fl) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic rd(input string name, input logic [4:0] r1, input logic [4:0] r2);
        cyc(name, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    // Monitor: compare whatever the ports show against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (rs1_busy !== e.b1 || rs1_value !== e.v1 || rs1_tag !== e.t1 ||
                    rs2_busy !== e.b2 || rs2_value !== e.v2 || rs2_tag !== e.t2) begin
                    fails++;
                    $display("FAIL %s: got rs1 b=%0b v=%h t=%0d rs2 b=%0b v=%h t=%0d; exp rs1 b=%0b v=%h t=%0d rs2 b=%0b v=%h t=%0d",
                             e.name, rs1_busy, rs1_value, rs1_tag, rs2_busy, rs2_value, rs2_tag,
                             e.b1, e.v1, e.t1, e.b2, e.v2, e.t2);
                end
            end
        end
    end

    initial begin
        logic          iss, com, fl, rdy;
        logic [4:0]    ird, crd, r1, r2;
        logic [RB-1:0] iid, cid;
        logic [31:0]   cval;
        model_clear();
        @(posedge clk_in);
        #1;
        // name, rst, rdy, iss, ird, iid, com, crd, cval, cid, fl, rs1, rs2
        cyc("reset_init",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        cyc("issue5_same",   1, 1, 1, 5, 3, 0, 0, 0, 0, 0, 5, 0);
        cyc("read5_busy",    1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        cyc("commit5",       1, 1, 0, 0, 0, 1, 5, 32'h1234, 3, 0, 5, 0);
        rd ("read5_ready", 5, 0);
        cyc("issue7_t2",     1, 1, 1, 7, 2, 0, 0, 0, 0, 0, 7, 0);
        cyc("issue7_t6",     1, 1, 1, 7, 6, 0, 0, 0, 0, 0, 7, 0);
        cyc("commit7_old",   1, 1, 0, 0, 0, 1, 7, 32'hAA, 2, 0, 0, 7);
        rd ("read7_younger", 7, 0);
        cyc("issue9_same",   1, 1, 1, 9, 4, 0, 0, 0, 0, 0, 9, 0);
        rd ("read9_busy", 9, 0);
        cyc("issue1",        1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("issue2",        1, 1, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0);
        cyc("issue3",        1, 1, 1, 3, 3, 0, 0, 0, 0, 0, 1, 2);
        cyc("flush_issue4",  1, 1, 1, 4, 5, 0, 0, 0, 0, 1, 1, 3);
        rd ("after_flush12", 1, 2);
        rd ("after_flush34", 3, 4);
        cyc("issue8",        1, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 8);
        cyc("commit8_byp",   1, 1, 0, 0, 0, 1, 8, 32'h55, 1, 0, 0, 8);
        rd ("read8_after", 0, 8);
        cyc("hold_rdy0",     1, 0, 1, 10, 9, 1, 5, 32'hDEAD, 0, 0, 10, 5);
        rd ("read_after_hold", 10, 5);
        cyc("x0_write",      1, 1, 1, 0, 7, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        rd ("x0_read", 0, 7);
        cyc("issue_commit_same", 1, 1, 1, 6, 8, 1, 6, 32'h77, 0, 0, 6, 0);
        rd ("read6_issue_wins", 6, 0);
        cyc("flush_commit",  1, 1, 0, 0, 0, 1, 6, 32'h99, 1, 1, 6, 0);
        rd ("read6_flushed", 6, 5);
        cyc("reset_mid",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
        rd ("after_reset", 5, 7);

        for (int n = 0; n < 1500; n++) begin
            rdy  = ($urandom_range(0, 7) != 0);
            iss  = $urandom_range(0, 1);
            ird  = 5'($urandom_range(0, 7));
            iid  = RB'($urandom);
            com  = $urandom_range(0, 1);
            crd  = 5'($urandom_range(0, 7));
            cval = $urandom;
            cid  = ($urandom_range(0, 3) != 0) ? m_tag[crd] : RB'($urandom);
            fl   = ($urandom_range(0, 15) == 0);
            r1   = ($urandom_range(0, 2) == 0) ? crd : 5'($urandom_range(0, 7));
            r2   = ($urandom_range(0, 2) == 0) ? ird : 5'($urandom_range(0, 31));
            cyc("random", 1, rdy, iss, ird, iid, com, crd, cval, cid, fl, r1, r2);
        end

        @(negedge clk_in);
        #1;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
